// File: rtl/alu_op_sequencer.sv
// Instruction sequencer: fetches, decodes and dispatches one ALU/move operation per start
// request, waits for the operation FSM with a bounded timeout, then advances the PC.
module alu_op_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       sub_done,
    output logic       IR_Load,
    output logic       ImData_Start,
    output logic       RegALU_Start,
    output logic       Move_Start,
    output logic       PC_Increment,
    output logic       Busy,
    output logic       Done,
    output logic       Illegal,
    output logic       Timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_DISPATCH = 3'd3,
        S_WAIT     = 3'd4,
        S_PC_INC   = 3'd5,
        S_DONE     = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_IMDATA = 4'h1;
    localparam logic [3:0] OP_REGALU = 4'h2;
    localparam logic [3:0] OP_MOVE   = 4'h3;
    localparam logic [3:0] TCNT_MAX  = 4'hF;

    function automatic logic is_dispatch_op(input logic [3:0] op);
        return (op >= OP_IMDATA) && (op <= OP_MOVE);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] tcnt_q, tcnt_d;

    logic ir_load_q, ir_load_d;
    logic imdata_start_q, imdata_start_d;
    logic regalu_start_q, regalu_start_d;
    logic move_start_q, move_start_d;
    logic pc_increment_q, pc_increment_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic illegal_q, illegal_d;
    logic timeout_q, timeout_d;

    // Next-state, opcode latch and WAIT timeout counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                if (opcode == OP_NOP) begin
                    state_d = S_PC_INC;
                end else if (is_dispatch_op(opcode)) begin
                    state_d = S_DISPATCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DISPATCH: begin
                tcnt_d  = 4'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over timeout when both land in the last counted cycle.
                if (sub_done) begin
                    state_d = S_PC_INC;
                end else if (tcnt_q == TCNT_MAX) begin
                    state_d = S_ERROR;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            S_PC_INC: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with the state.
    always_comb begin
        ir_load_d      = 1'b0;
        imdata_start_d = 1'b0;
        regalu_start_d = 1'b0;
        move_start_d   = 1'b0;
        pc_increment_d = 1'b0;
        done_d         = 1'b0;
        illegal_d      = 1'b0;
        timeout_d      = 1'b0;
        busy_d         = (state_d != S_IDLE);
        case (state_d)
            S_FETCH: ir_load_d = 1'b1;
            S_DISPATCH: begin
                case (op_d)
                    OP_IMDATA: imdata_start_d = 1'b1;
                    OP_REGALU: regalu_start_d = 1'b1;
                    OP_MOVE:   move_start_d   = 1'b1;
                    default:   imdata_start_d = 1'b0;
                endcase
            end
            S_PC_INC: pc_increment_d = 1'b1;
            S_DONE: begin
                done_d    = 1'b1;
                illegal_d = (op_d > OP_MOVE);
            end
            S_ERROR: timeout_d = 1'b1;
            default: busy_d = (state_d != S_IDLE);
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            op_q           <= 4'd0;
            tcnt_q         <= 4'd0;
            ir_load_q      <= 1'b0;
            imdata_start_q <= 1'b0;
            regalu_start_q <= 1'b0;
            move_start_q   <= 1'b0;
            pc_increment_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            tcnt_q         <= tcnt_d;
            ir_load_q      <= ir_load_d;
            imdata_start_q <= imdata_start_d;
            regalu_start_q <= regalu_start_d;
            move_start_q   <= move_start_d;
            pc_increment_q <= pc_increment_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            illegal_q      <= illegal_d;
            timeout_q      <= timeout_d;
        end
    end

    assign IR_Load      = ir_load_q;
    assign ImData_Start = imdata_start_q;
    assign RegALU_Start = regalu_start_q;
    assign Move_Start   = move_start_q;
    assign PC_Increment = pc_increment_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Illegal      = illegal_q;
    assign Timeout      = timeout_q;

endmodule
